// File: rtl/zymason_seg_bank.sv
// zymason_seg_bank: NUM_DIGITS-deep segment store written by nibbles, scanned with a one-hot digit enable
// Ports: clock, reset (sync, active-high); RW (1 write / 0 scan), sel (nibble select),
//   pin_in (write nibble), spd (scan divider, 0 freezes), dir (0 up / 1 down),
//   blink_mask (per-digit blink request); seg_out (current pattern), dig_en (one-hot),
//   dig_idx (binary index), st_out (FSM state), mode (mirrors RW).
// Optional feature: define ZYM_BLINK_EN to blank masked digits on alternate blink phases.
module zymason_seg_bank #(
  parameter int NUM_DIGITS = 8,
  parameter int SEG_W = 7,
  parameter int PRESCALE_W = 9,
  parameter int SPD_W = 5,
  parameter int BLINK_DIV = 4,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  RW,
  input  logic                  sel,
  input  logic [3:0]            pin_in,
  input  logic [SPD_W-1:0]      spd,
  input  logic                  dir,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [IDX_W-1:0]      dig_idx,
  output logic [1:0]            st_out,
  output logic                  mode
);
  typedef enum logic [1:0] {INIT = 2'b00, SCAN = 2'b01, WLO = 2'b10, WHI = 2'b11} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, ptr_inc, ptr_dec;
  logic [SEG_W-1:0] mem [NUM_DIGITS];
  logic [PRESCALE_W-1:0] tb;
  logic [SPD_W-1:0] div;
  logic strobe, pulse, blank;
  assign strobe = tb == '0;
  // >= rather than == so that lowering spd mid-count fires on the next strobe
  assign pulse = strobe && spd != '0 && div >= spd - 1'b1;
  assign ptr_inc = ptr == IDX_W'(NUM_DIGITS - 1) ? '0 : ptr + 1'b1;
  assign ptr_dec = ptr == '0 ? IDX_W'(NUM_DIGITS - 1) : ptr - 1'b1;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      ptr <= '0;
      tb <= '0;
      div <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) mem[i] <= '0;
    end else begin
      tb <= tb + 1'b1;
      div <= spd == '0 ? '0 : !strobe ? div : pulse ? '0 : div + 1'b1;
      case (state)
        INIT, SCAN: begin
          state <= RW ? WLO : SCAN;
          if (state == SCAN && !RW && pulse) ptr <= dir ? ptr_dec : ptr_inc;
        end
        WLO: begin
          state <= sel ? WHI : WLO;
          if (RW && !sel) mem[ptr][3:0] <= pin_in;
        end
        default: begin
          state <= !RW ? SCAN : sel ? WHI : WLO;
          if (RW && sel) mem[ptr][SEG_W-1:4] <= pin_in[SEG_W-5:0];
          if (RW && !sel) ptr <= ptr_inc;
        end
      endcase
    end
  end
`ifdef ZYM_BLINK_EN
  localparam int BC_W = $clog2(BLINK_DIV + 1);
  logic [BC_W-1:0] bcnt;
  logic phase;
  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (pulse) begin
      bcnt <= bcnt == BC_W'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      phase <= bcnt == BC_W'(BLINK_DIV - 1) ? ~phase : phase;
    end
  end
  assign blank = state == SCAN && phase && blink_mask[ptr];
`else
  logic unused_mask;
  assign unused_mask = ^blink_mask;
  assign blank = 1'b0;
`endif
  assign seg_out = blank ? '0 : mem[ptr];
  assign dig_en = NUM_DIGITS'(1) << ptr;
  assign dig_idx = ptr;
  assign st_out = state;
  assign mode = RW;
endmodule
